// File: rtl/bf16_adder_arbiter.sv
// Round-robin arbiter sharing one free-running bfloat16 adder between N_REQ requesters.
// Grants land on adder ready pulses; results are returned tagged with the owner ID, with a watchdog abort.
module bf16_adder_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [16*N_REQ-1:0]   i_req_a,
    input  logic [16*N_REQ-1:0]   i_req_b,
    output logic [N_REQ-1:0]      o_req_ready,
    output logic [15:0]           o_add_a,
    output logic [15:0]           o_add_b,
    input  logic                  i_add_ready,
    input  logic [15:0]           i_add_sum,
    output logic                  o_resp_valid,
    output logic [ID_W-1:0]       o_resp_id,
    output logic [15:0]           o_resp_sum,
    output logic                  o_resp_err,
    output logic                  o_busy
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [15:0] NAN_ABORT = 16'h7FC1;
    localparam logic [7:0]  WD_LAST   = 8'(TIMEOUT - 2);

    state_t            r_state, w_state_nxt;
    logic [ID_W-1:0]   r_rr, r_cur_id, w_win;
    logic [7:0]        r_wd;
    logic [N_REQ-1:0]  w_above, w_masked;
    logic              w_launch, w_result, w_timeout;
    logic [15:0]       w_a, w_b;
    logic [15:0]       r_add_a, r_add_b, r_resp_sum;
    logic [ID_W-1:0]   r_resp_id;
    logic              r_resp_valid, r_resp_err;

    assign w_launch  = i_add_ready && (|i_req_valid);
    assign w_result  = (r_state == S_BUSY) && i_add_ready;
    assign w_timeout = (r_state == S_BUSY) && !i_add_ready && (r_wd == WD_LAST);

    // Prefer the lowest requester above the last winner; otherwise wrap to the lowest set bit.
    always_comb begin
        w_win = '0;
        for (int i = 0; i < N_REQ; i++) w_above[i] = ID_W'(i) > r_rr;
        w_masked = i_req_valid & w_above;
        for (int i = N_REQ-1; i >= 0; i--) if (i_req_valid[i]) w_win = ID_W'(i);
        for (int i = N_REQ-1; i >= 0; i--) if (w_masked[i]) w_win = ID_W'(i);
    end

    always_comb begin
        o_req_ready = '0;
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                o_req_ready[i] = w_launch;
                w_a = i_req_a[16*i +: 16];
                w_b = i_req_b[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_launch) w_state_nxt = S_BUSY;
            S_BUSY: begin
                if (i_add_ready)    w_state_nxt = w_launch ? S_BUSY : S_IDLE;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_rr         <= ID_W'(N_REQ - 1);
            r_cur_id     <= '0;
            r_wd         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_id    <= '0;
            r_resp_sum   <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            if (w_launch) begin
                r_add_a  <= w_a;
                r_add_b  <= w_b;
                r_rr     <= w_win;
                r_cur_id <= w_win;
                r_wd     <= '0;
            end else if (r_state == S_BUSY && !i_add_ready) begin
                r_wd <= r_wd + 8'd1;
            end
            // A result and a back-to-back launch can share a cycle; the reply still carries the old owner.
            if (w_result) begin
                r_resp_valid <= 1'b1;
                r_resp_sum   <= i_add_sum;
                r_resp_id    <= r_cur_id;
            end else if (w_timeout) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b1;
                r_resp_sum   <= NAN_ABORT;
                r_resp_id    <= r_cur_id;
            end
        end
    end

    assign o_add_a      = r_add_a;
    assign o_add_b      = r_add_b;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_resp_id    = r_resp_id;
    assign o_resp_sum   = r_resp_sum;
    assign o_busy       = (r_state == S_BUSY);
endmodule

// File: tb/tb_bf16_adder_arbiter.sv
// Directed bench for bf16_adder_arbiter with a table-driven adder model that pulses ready every 6 cycles.
module tb_bf16_adder_arbiter;
    logic              clock, nreset;
    logic [3:0]        req_valid, req_ready;
    logic [63:0]       req_a, req_b;
    logic [15:0]       add_a, add_b, add_sum, resp_sum;
    logic              add_ready, resp_valid, resp_err, busy, stall;
    logic [1:0]        resp_id;

    int issued [4];
    int granted[4];
    int cyc = 0;
    int n_chk = 0, n_err = 0;
    int          g_id[$], g_cyc[$], rs_id[$], rs_cyc[$];
    logic [15:0] rs_sum[$];
    logic        rs_err[$];

    logic [2:0]  a_cnt;
    logic [15:0] a_sa, a_res;

    bf16_adder_arbiter #(.N_REQ(4), .ID_W(2), .TIMEOUT(16)) dut (
        .clock(clock), .nreset(nreset),
        .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b), .o_req_ready(req_ready),
        .o_add_a(add_a), .o_add_b(add_b), .i_add_ready(add_ready), .i_add_sum(add_sum),
        .o_resp_valid(resp_valid), .o_resp_id(resp_id), .o_resp_sum(resp_sum),
        .o_resp_err(resp_err), .o_busy(busy)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] f_add(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3F80_3F80: return 16'h4000;
            32'h3F80_4000: return 16'h4040;
            32'h4000_4000: return 16'h4080;
            32'hC000_4000: return 16'h0000;
            32'h7F80_3F80: return 16'h7F80;
            default:       return 16'hDEAD;
        endcase
    endfunction

    // Adder model: ready at cnt 0, samples a at cnt 1, b at cnt 2, result held until next ready.
    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            a_cnt <= '0; a_sa <= '0; a_res <= '0;
        end else begin
            a_cnt <= (a_cnt == 3'd5) ? 3'd0 : a_cnt + 3'd1;
            if (a_cnt == 3'd1) a_sa <= add_a;
            if (a_cnt == 3'd2) a_res <= f_add(a_sa, add_b);
        end
    end
    assign add_ready = (a_cnt == 3'd0) && !stall;
    assign add_sum   = a_res;

    always_comb begin
        for (int i = 0; i < 4; i++) req_valid[i] = issued[i] > granted[i];
    end

    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < 4; i++) granted[i] <= 0;
        end else begin
            for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) granted[i] <= granted[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        if (nreset) begin
            for (int i = 0; i < 4; i++) if (req_ready[i]) begin g_id.push_back(i); g_cyc.push_back(cyc); end
            if (req_ready != 4'b0)
                chk("grant_legal", {31'b0, $onehot(req_ready) && add_ready && ((req_ready & ~req_valid) == 4'b0)}, 1);
            if (resp_valid) begin
                rs_id.push_back(int'(resp_id)); rs_sum.push_back(resp_sum);
                rs_err.push_back(resp_err); rs_cyc.push_back(cyc);
            end
        end
    end

    task automatic clr();
        g_id.delete(); g_cyc.delete(); rs_id.delete(); rs_sum.delete(); rs_err.delete(); rs_cyc.delete();
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic wait_resp(input int n, input int budget);
        int k = 0;
        while (rs_id.size() < n && k < budget) begin @(negedge clock); k++; end
        @(negedge clock);
        if (rs_id.size() < n) chk("resp_wait", rs_id.size(), n);
    endtask

    task automatic wait_grant(input int budget);
        int k = 0;
        @(negedge clock);
        while (req_ready == 4'b0 && k < budget) begin @(negedge clock); k++; end
        if (req_ready == 4'b0) chk("grant_wait", 0, 1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_adda"}, add_a, 0);
        chk({tag, "_addb"}, add_b, 0);
        chk({tag, "_rvalid"}, resp_valid, 0);
        chk({tag, "_rid"}, resp_id, 0);
        chk({tag, "_rsum"}, resp_sum, 0);
        chk({tag, "_rerr"}, resp_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        nreset = 0; stall = 0; req_a = '0; req_b = '0;
        for (int i = 0; i < 4; i++) issued[i] = 0;
        repeat (2) @(negedge clock);
        chk_reset_outs("rst");
        nreset = 1;

        // Single request from requester 0: 1.0 + 1.0
        clr(); set_op(0, 16'h3F80, 16'h3F80); issued[0]++;
        wait_resp(1, 60);
        chk("t1_gid", g_id[0], 0);
        chk("t1_rid", rs_id[0], 0);
        chk("t1_sum", rs_sum[0], 16'h4000);
        chk("t1_err", rs_err[0], 0);
        chk("t1_busy", busy, 0);

        // Requesters 1 and 3 together; 3 launches on 1's result pulse
        clr(); set_op(1, 16'h3F80, 16'h4000); set_op(3, 16'hC000, 16'h4000);
        issued[1]++; issued[3]++;
        wait_resp(2, 80);
        chk("t2_g0", g_id[0], 1);
        chk("t2_g1", g_id[1], 3);
        chk("t2_r0id", rs_id[0], 1);
        chk("t2_r0sum", rs_sum[0], 16'h4040);
        chk("t2_r1id", rs_id[1], 3);
        chk("t2_r1sum", rs_sum[1], 16'h0000);
        chk("t2_b2b", rs_cyc[0] - g_cyc[1], 1);

        // All four continuously for 8 operations
        clr(); set_op(0, 16'h3F80, 16'h3F80); set_op(2, 16'h4000, 16'h4000);
        for (int i = 0; i < 4; i++) issued[i] += 2;
        wait_resp(8, 200);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t3_g%0d", k), g_id[k], k % 4);
            chk($sformatf("t3_rid%0d", k), rs_id[k], k % 4);
        end
        chk("t3_sum0", rs_sum[0], 16'h4000);
        chk("t3_sum1", rs_sum[1], 16'h4040);
        chk("t3_sum2", rs_sum[2], 16'h4080);
        chk("t3_sum3", rs_sum[3], 16'h0000);
        chk("t3_sum6", rs_sum[6], 16'h4080);

        // Infinity operand
        clr(); set_op(2, 16'h7F80, 16'h3F80); issued[2]++;
        wait_resp(1, 60);
        chk("t4_rid", rs_id[0], 2);
        chk("t4_sum", rs_sum[0], 16'h7F80);
        chk("t4_err", rs_err[0], 0);

        // Adder stalls after launch: watchdog abort 16 cycles later
        clr(); set_op(1, 16'h3F80, 16'h3F80); issued[1]++;
        wait_grant(40);
        @(posedge clock); #1 stall = 1;
        wait_resp(1, 40);
        chk("t5_err", rs_err[0], 1);
        chk("t5_sum", rs_sum[0], 16'h7FC1);
        chk("t5_rid", rs_id[0], 1);
        chk("t5_lat", rs_cyc[0] - g_cyc[0], 16);
        chk("t5_busy", busy, 0);
        stall = 0;
        repeat (15) @(negedge clock);
        chk("t5_nostale", rs_id.size(), 1);

        // Reset 3 cycles after a launch, then round-robin restarts at requester 0
        clr(); set_op(0, 16'h3F80, 16'h3F80); issued[0]++;
        wait_grant(40);
        repeat (3) @(negedge clock);
        for (int i = 0; i < 4; i++) issued[i] = 0;
        nreset = 0;
        #1 chk_reset_outs("mid_rst");
        repeat (2) @(negedge clock);
        nreset = 1;
        repeat (15) @(negedge clock);
        chk("t6_noresp", rs_id.size(), 0);
        clr(); set_op(2, 16'h7F80, 16'h3F80); issued[0]++; issued[2]++;
        wait_resp(2, 80);
        chk("t6_g0", g_id[0], 0);
        chk("t6_g1", g_id[1], 2);
        chk("t6_r0sum", rs_sum[0], 16'h4000);
        chk("t6_r1id", rs_id[1], 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/bf16_adder_arbiter.md
Name: bf16_adder_arbiter

Overview:
Shares one free-running multi-cycle bfloat16_adder between N_REQ requesters.
- Arbitration is round-robin. Each grant is issued only on an adder ready cycle, so the operands land exactly when the adder samples them.
- Each grant is tracked to its result, and the sum is returned tagged with the requester ID.
- A watchdog aborts operations whose result never arrives.
- Sits between the vector/accumulator front-ends and the single adder instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must be >= clog2(N_REQ)
TIMEOUT, 16, max cycles in BUSY without add_ready before abort (4..255)

Ports:
clock  in  1  clock
nreset  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester operation request, held until granted
req_a  in  16*N_REQ  operand A per requester, slice i = [16*i+15:16*i]
req_b  in  16*N_REQ  operand B per requester, same slicing
req_ready  out  N_REQ  one-hot grant pulse; request i consumed on the cycle req_valid[i] && req_ready[i]
add_a  out  16  operand A to adder a
add_b  out  16  operand B to adder b
add_ready  in  1  adder ready output
add_sum  in  16  adder sum output
resp_valid  out  1  one-cycle result pulse, no backpressure
resp_id  out  ID_W  requester that owns the result
resp_sum  out  16  result value
resp_err  out  1  with resp_valid: timeout abort, resp_sum = 16'h7FC1 (NaN)
busy  out  1  operation in flight

Behaviour:
- Reset is asynchronous and active-low on nreset; clock is clock.
- Values on reset: state IDLE, add_a/add_b 0, req_ready 0, resp_valid 0, resp_id 0, resp_sum 0, resp_err 0, busy 0, rr pointer = N_REQ-1 (requester 0 has first priority), watchdog 0.
- Adder contract:
  - The adder pulses add_ready for one cycle, samples a on the following cycle, then samples b on the cycle after that.
  - add_sum holds the previous operation's result while add_ready=1.
  - One adder operation spans 5..10 cycles between ready pulses.
- The launch condition L is add_ready=1 && |req_valid. On L:
  - Select the winner: the first set bit of req_valid searching from rr+1 upward, wrapping at N_REQ.
  - Register add_a/add_b from the winner's slices.
  - Assert req_ready[winner] combinationally in that cycle.
  - Set rr = winner, latch cur_id = winner, clear the watchdog, and go to BUSY.
- Operands are registered, so they are valid from the cycle after the ready pulse. They are held unchanged until the next launch.
- FSM IDLE:
  - L causes a launch and the move to BUSY.
  - add_ready with no request does nothing, and the adder computes stale operands whose result is ignored.
- FSM BUSY:
  - The watchdog increments each cycle with add_ready=0.
  - On add_ready=1 (the result arrives): resp_valid=1 next cycle, resp_sum=add_sum, resp_id=cur_id, resp_err=0.
  - In that same cycle, if L then launch back-to-back and stay in BUSY; otherwise go to IDLE.
- Response to a result is registered: resp_valid is high exactly one cycle after the result ready pulse.
- Timeout: when the watchdog reaches TIMEOUT-1 in BUSY without add_ready:
  - Pulse resp_valid with resp_err=1, resp_id=cur_id, resp_sum=16'h7FC1.
  - Go to IDLE.
  - The next add_ready is treated as a plain IDLE slot, and a stale result is never reported.
- busy = (state == BUSY).
- Grants:
  - At most one req_ready bit is set per cycle.
  - req_ready is never set when add_ready=0.
  - Requesters not granted keep req_valid and operands stable.
- Fairness: with all requesters asserted continuously, grants follow 0,1,2,...,N_REQ-1,0 with no repeat before the others are served.
- Reset mid-operation: everything returns to reset values immediately. The in-flight result is discarded with no resp_valid pulse. The adder shares nreset.
- req_valid bits at index >= N_REQ do not exist. Unused ID bits are 0.

Test Plan:
- Req0 a=16'h3F80, b=16'h3F80 -> req_ready[0] pulses on an add_ready cycle; resp_valid with resp_id=0, resp_sum=16'h4000, resp_err=0; then busy=0.
- Req1 a=16'h3F80 (1.0), b=16'h4000 (2.0), req3 a=16'hC000 (-2.0), b=16'h4000 (2.0), both valid at once -> grant req1 first, then req3 back-to-back on the result ready pulse; results 16'h4040 id1, then 16'h0000 id3.
- All four valid continuously for 8 operations -> grant order 0,1,2,3,0,1,2,3; one resp per grant, IDs in the same order.
- Req2 a=16'h7F80 (+inf), b=16'h3F80 -> resp_sum=16'h7F80, resp_id=2.
- Model the adder with add_ready stuck 0 after launch, TIMEOUT=16 -> resp_valid with resp_err=1, resp_sum=16'h7FC1 16 cycles after launch; state IDLE; a later ready pulse produces no response.
- Assert nreset low 3 cycles after a launch -> outputs at reset values, no resp_valid; after release, rr restarts at requester 0.
